// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length stream encoder.
// Imported by the encoder top level and its run tracker.
package rle_pkg;

    typedef enum logic [2:0] {
        FETCH,
        EVAL,
        SYM,
        CNT,
        LIT
    } state_t;

    localparam int MODE_ZERO  = 0;
    localparam int MODE_VALUE = 1;

    function automatic int unsigned max_run(input int unsigned count_w);
        return (32'd1 << count_w) - 32'd1;
    endfunction

endpackage

// File: rtl/rle_run_tracker.sv
// Holds the open run (value and count) and classifies each new sample
// as extending the run, terminating it, or passing through as a literal.
module rle_run_tracker #(
    parameter int DATA_W  = 16,
    parameter int COUNT_W = 16,
    parameter int MODE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  sample,
    input  logic               update,
    input  logic               clear,
    output logic [DATA_W-1:0]  run_val,
    output logic [COUNT_W-1:0] run_cnt,
    output logic               extend,
    output logic               terminate,
    output logic               literal
);
    import rle_pkg::*;

    localparam logic [COUNT_W-1:0] MAX = COUNT_W'(max_run(COUNT_W));

    // Classify the held sample against the open run
    always_comb begin
        extend    = 1'b0;
        literal   = 1'b0;
        if (MODE == MODE_ZERO) begin
            extend  = (sample == '0) && (run_cnt != MAX);
            literal = (sample != '0);
        end else begin
            extend  = (run_cnt != '0) && (sample == run_val)
                      && (run_cnt != MAX);
        end
        terminate = (run_cnt != '0) && !extend;
    end

    // Extend, reopen or drop the run when the sample is consumed
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_val <= '0;
            run_cnt <= '0;
        end else if (update) begin
            if (extend) begin
                run_cnt <= run_cnt + COUNT_W'(1);
            end else if (literal) begin
                run_val <= '0;
                run_cnt <= '0;
            end else begin
                run_val <= sample;
                run_cnt <= COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rle_stream_encoder.sv
// Run-length encoder between an upstream FIFO and a downstream sink.
// Emits SYM/CNT pairs and literals, flushing any open run at frame end.
module rle_stream_encoder #(
    parameter int DATA_W    = 16,
    parameter int COUNT_W   = 16,
    parameter int FRAME_LEN = 1600,
    parameter int MODE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              avail_in,
    output logic              read_in,
    output logic [DATA_W-1:0] data_out,
    output logic              write_out,
    output logic              eof_out,
    input  logic              afull_out
);
    import rle_pkg::*;

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t              state;
    state_t              state_nx;
    logic [DATA_W-1:0]   sample;
    logic [IDX_W-1:0]    index;
    logic [DATA_W-1:0]   sym_q;
    logic [COUNT_W-1:0]  cnt_q;
    logic                term_pend;
    logic                lit_pend;
    logic                flush_pend;
    logic                frame_end;
    logic [DATA_W-1:0]   run_val;
    logic [COUNT_W-1:0]  run_cnt;
    logic                extend;
    logic                terminate;
    logic                literal;
    logic                last;
    logic                emit;
    logic                flush_done;

    assign last       = (index == LAST_IDX);
    assign emit       = (state == SYM) || (state == CNT) || (state == LIT);
    assign read_in    = (state == FETCH) && avail_in && !rst;
    assign write_out  = emit && !afull_out && !rst;
    assign flush_done = (state == CNT) && write_out && !term_pend;

    rle_run_tracker #(
        .DATA_W  (DATA_W),
        .COUNT_W (COUNT_W),
        .MODE    (MODE)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample),
        .update    (state == EVAL),
        .clear     (flush_done),
        .run_val   (run_val),
        .run_cnt   (run_cnt),
        .extend    (extend),
        .terminate (terminate),
        .literal   (literal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // Next state and output word selection
    always_comb begin
        state_nx = state;
        data_out = '0;
        eof_out  = 1'b0;
        unique case (state)
            FETCH: begin
                if (read_in) state_nx = EVAL;
            end
            EVAL: begin
                if (terminate || (last && !literal)) state_nx = SYM;
                else if (extend || !literal)         state_nx = FETCH;
                else                                 state_nx = LIT;
            end
            SYM: begin
                data_out = term_pend ? sym_q : run_val;
                if (write_out) state_nx = CNT;
            end
            CNT: begin
                data_out = DATA_W'(term_pend ? cnt_q : run_cnt);
                eof_out  = frame_end
                           && (!term_pend || (!lit_pend && !flush_pend));
                if (write_out) begin
                    if (!term_pend)     state_nx = FETCH;
                    else if (lit_pend)  state_nx = LIT;
                    else if (flush_pend) state_nx = SYM;
                    else                state_nx = FETCH;
                end
            end
            LIT: begin
                data_out = sample;
                eof_out  = frame_end && !flush_pend;
                if (write_out) state_nx = flush_pend ? SYM : FETCH;
            end
            default: state_nx = FETCH;
        endcase
        if (rst) begin
            data_out = '0;
            eof_out  = 1'b0;
        end
    end

    // Sample capture, frame index and pending-emit bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            sample     <= '0;
            index      <= '0;
            sym_q      <= '0;
            cnt_q      <= '0;
            term_pend  <= 1'b0;
            lit_pend   <= 1'b0;
            flush_pend <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            if (read_in) sample <= data_in;
            if (state == EVAL) begin
                index      <= last ? '0 : index + IDX_W'(1);
                sym_q      <= run_val;
                cnt_q      <= run_cnt;
                term_pend  <= terminate;
                lit_pend   <= literal;
                flush_pend <= last && !literal;
                frame_end  <= last;
            end
            if ((state == CNT) && write_out && term_pend) term_pend <= 1'b0;
            if (flush_done) flush_pend <= 1'b0;
            if ((state == LIT) && write_out) lit_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Testbench for rle_stream_encoder: directed tables, corner sequences
// and randomized frames compared against a stream-level RLE model.
module tb_rle_stream_encoder;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avail [NDUT];
    logic        rd    [NDUT];
    logic        wr    [NDUT];
    logic        eof   [NDUT];
    logic        afull [NDUT];
    logic [15:0] din   [NDUT];
    logic [15:0] dout  [NDUT];

    logic [15:0] inq   [NDUT][$];
    logic [16:0] outq  [NDUT][$];
    logic [15:0] stim_q[$];
    logic [16:0] exp_q [$];

    int passed = 0;
    int total  = 0;
    int gap_pct = 0;
    int af_pct  = 0;
    int burst [NDUT];
    logic        pv_af [NDUT];
    logic [15:0] pv_d  [NDUT];
    logic        pv_e  [NDUT];

    always #5 clk = ~clk;

    // 0: zero-run, frame 8; 1: zero-run, frame 20;
    // 2: value-run, frame 8; 3: value-run, 3-bit count, frame 8
    rle_stream_encoder #(.DATA_W(16), .COUNT_W(4), .FRAME_LEN(8), .MODE(0)) u_z8 (
        .clk(clk), .rst(rst), .data_in(din[0]), .avail_in(avail[0]),
        .read_in(rd[0]), .data_out(dout[0]), .write_out(wr[0]),
        .eof_out(eof[0]), .afull_out(afull[0]));
    rle_stream_encoder #(.DATA_W(16), .COUNT_W(4), .FRAME_LEN(20), .MODE(0)) u_z20 (
        .clk(clk), .rst(rst), .data_in(din[1]), .avail_in(avail[1]),
        .read_in(rd[1]), .data_out(dout[1]), .write_out(wr[1]),
        .eof_out(eof[1]), .afull_out(afull[1]));
    rle_stream_encoder #(.DATA_W(16), .COUNT_W(4), .FRAME_LEN(8), .MODE(1)) u_v8 (
        .clk(clk), .rst(rst), .data_in(din[2]), .avail_in(avail[2]),
        .read_in(rd[2]), .data_out(dout[2]), .write_out(wr[2]),
        .eof_out(eof[2]), .afull_out(afull[2]));
    rle_stream_encoder #(.DATA_W(16), .COUNT_W(3), .FRAME_LEN(8), .MODE(1)) u_v8s (
        .clk(clk), .rst(rst), .data_in(din[3]), .avail_in(avail[3]),
        .read_in(rd[3]), .data_out(dout[3]), .write_out(wr[3]),
        .eof_out(eof[3]), .afull_out(afull[3]));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Input driver: FIFO model with random gaps and 5-cycle afull bursts
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            avail[k] = 1'b0; din[k] = 16'h0; afull[k] = 1'b0; burst[k] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                avail[k] = (inq[k].size() > 0)
                           && (int'($urandom_range(99)) >= gap_pct);
                din[k] = (inq[k].size() > 0) ? inq[k][0] : 16'h0;
                if (burst[k] > 0) begin
                    afull[k] = 1'b1;
                    burst[k]--;
                end else if (int'($urandom_range(99)) < af_pct) begin
                    afull[k] = 1'b1;
                    burst[k] = 4;
                end else begin
                    afull[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: pop on read, log writes, check hold behaviour under afull
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            pv_af[k] = 1'b0; pv_d[k] = 16'h0; pv_e[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (!rst) begin
                    if (rd[k] && inq[k].size() > 0) void'(inq[k].pop_front());
                    if (wr[k]) outq[k].push_back({eof[k], dout[k]});
                    if (afull[k]) chk("wr_while_afull", int'(wr[k]), 0);
                    if (pv_af[k] && pv_d[k] != 16'h0)
                        chk("hold_stable", int'({eof[k], dout[k]}),
                            int'({pv_e[k], pv_d[k]}));
                end
                pv_af[k] = afull[k] && !rst;
                pv_d[k]  = dout[k];
                pv_e[k]  = eof[k];
            end
        end
    end

    // Push stim_q into DUT k, wait for the words, compare with exp_q
    task automatic run_case(input int k, input string name);
        int t;
        foreach (stim_q[i]) inq[k].push_back(stim_q[i]);
        t = 0;
        while ((inq[k].size() != 0 || outq[k].size() < exp_q.size())
               && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk({name, "_len"}, outq[k].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < outq[k].size(); i++)
            chk({name, "_word"}, int'(outq[k][i]), int'(exp_q[i]));
        outq[k].delete();
    endtask

    // Stream-level RLE reference: walks samples, counting runs per frame
    task automatic model(input int mode, input int maxr, input int fl);
        int run;
        logic [15:0] val;
        logic [16:0] tmp;
        exp_q.delete();
        run = 0;
        val = 16'h0;
        for (int i = 0; i < stim_q.size(); i++) begin
            logic [15:0] s;
            s = stim_q[i];
            if (mode == 0) begin
                if (s != 16'h0) begin
                    if (run > 0) begin
                        exp_q.push_back(17'h0);
                        exp_q.push_back({1'b0, 16'(run)});
                    end
                    exp_q.push_back({1'b0, s});
                    run = 0;
                end else begin
                    if (run == maxr) begin
                        exp_q.push_back(17'h0);
                        exp_q.push_back({1'b0, 16'(maxr)});
                        run = 0;
                    end
                    run++;
                end
            end else begin
                if (run > 0 && s == val && run < maxr) begin
                    run++;
                end else begin
                    if (run > 0) begin
                        exp_q.push_back({1'b0, val});
                        exp_q.push_back({1'b0, 16'(run)});
                    end
                    val = s;
                    run = 1;
                end
            end
            if ((i + 1) % fl == 0) begin
                if (run > 0) begin
                    exp_q.push_back({1'b0, val});
                    exp_q.push_back({1'b0, 16'(run)});
                end
                tmp = exp_q.pop_back();
                tmp[16] = 1'b1;
                exp_q.push_back(tmp);
                run = 0;
                val = 16'h0;
            end
        end
    endtask

    typedef struct {
        int               k;
        logic [0:7][15:0] din;
        int               n;
        logic [0:7][15:0] dout;
    } vec_t;

    function automatic logic [0:7][15:0] p8(input int a, b, c, d, e, f, g, h);
        return {a[15:0], b[15:0], c[15:0], d[15:0],
                e[15:0], f[15:0], g[15:0], h[15:0]};
    endfunction

    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, p8(5,0,0,0,7,0,0,9), 7, p8(5,0,3,7,0,2,9,0)};
        tbl[1] = '{0, p8(1,0,0,0,0,0,0,0), 3, p8(1,0,7,0,0,0,0,0)};
        tbl[2] = '{0, p8(0,0,0,0,0,0,0,0), 2, p8(0,8,0,0,0,0,0,0)};
        tbl[3] = '{2, p8(3,3,3,4,4,9,9,9), 6, p8(3,3,4,2,9,3,0,0)};
        tbl[4] = '{3, p8(5,5,5,5,5,5,5,5), 4, p8(5,7,5,1,0,0,0,0)};
        tbl[5] = '{3, p8(1,2,2,2,2,2,2,2), 4, p8(1,1,2,7,0,0,0,0)};

        // Reset values, with a sample waiting upstream
        rst = 1'b1;
        inq[0].push_back(16'h5);
        repeat (3) @(negedge clk);
        chk("rst_read", int'(rd[0]), 0);
        chk("rst_write", int'(wr[0]), 0);
        chk("rst_eof", int'(eof[0]), 0);
        chk("rst_data", int'(dout[0]), 0);
        inq[0].delete();
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed table
        for (int v = 0; v < 6; v++) begin
            stim_q.delete();
            exp_q.delete();
            for (int i = 0; i < 8; i++) stim_q.push_back(tbl[v].din[i]);
            for (int i = 0; i < tbl[v].n; i++)
                exp_q.push_back({(i == tbl[v].n - 1), tbl[v].dout[i]});
            run_case(tbl[v].k, $sformatf("vec%0d", v));
        end

        // Twenty zeros through a 20-sample frame: saturation then flush
        stim_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(16'h0);
        exp_q.push_back(17'h00000);
        exp_q.push_back(17'h0000f);
        exp_q.push_back(17'h00000);
        exp_q.push_back(17'h10005);
        run_case(1, "zero20");

        // Heavy backpressure with avail gaps: same value-run stream
        gap_pct = 30;
        af_pct  = 60;
        stim_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(tbl[3].din[i]);
        for (int i = 0; i < 6; i++)
            exp_q.push_back({(i == 5), tbl[3].dout[i]});
        run_case(2, "bp_value");
        gap_pct = 0;
        af_pct  = 0;
        repeat (8) @(negedge clk);

        // Reset in the middle of an open zero run
        inq[0].push_back(16'h0);
        inq[0].push_back(16'h0);
        inq[0].push_back(16'h0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_write", int'(wr[0]), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_noout", outq[0].size(), 0);
        stim_q.delete();
        exp_q.delete();
        stim_q = '{16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_q  = '{17'h00002, 17'h00000, 17'h10007};
        run_case(0, "after_rst");

        // Randomized frames against the reference model
        gap_pct = 25;
        af_pct  = 15;
        for (int r = 0; r < 3; r++) begin
            stim_q.delete();
            for (int i = 0; i < 48; i++)
                stim_q.push_back(($urandom_range(99) < 65) ? 16'h0
                                 : 16'($urandom_range(65535)));
            model(0, 15, 8);
            run_case(0, "rnd_z8");

            stim_q.delete();
            for (int i = 0; i < 60; i++)
                stim_q.push_back(($urandom_range(99) < 85) ? 16'h0
                                 : 16'($urandom_range(1, 65535)));
            model(0, 15, 20);
            run_case(1, "rnd_z20");

            stim_q.delete();
            for (int i = 0; i < 40; i++)
                stim_q.push_back(16'($urandom_range(1)) + 16'h8);
            model(1, 15, 8);
            run_case(2, "rnd_v8");

            stim_q.delete();
            for (int i = 0; i < 48; i++)
                stim_q.push_back(16'($urandom_range(2)));
            model(1, 7, 8);
            run_case(3, "rnd_v8s");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
